// File: rtl/hex_seq_monitor.sv
// rtl/hex_seq_monitor.sv - seven-segment digit sequence monitor with error counting
//
// Purpose:
//   Watches the active-low seven-segment pattern of a display that steps
//   through a five-entry digit table (D0..D4), forward or backward. The
//   monitor tracks the display's position in that table. It flags every
//   pattern that breaks the sequence and counts those errors, saturating
//   at 8'hFF.
//
// Build option:
//   HEX_SEQ_MONITOR_STICKY_ERR_EN
//     Defined:   err stays high from the first error until reset.
//     Undefined: err is high only for the sample that recorded an error.
//
// Ports:
//   clk        in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   hex        in   7  observed segments, active-low, bit0=a .. bit6=g
//   dir        in   1  display direction: 0 = D0->D4, 1 = D4->D0
//   sample     in   1  hex/dir/dut_rst are valid this cycle
//   dut_rst    in   1  the display FSM was reset this step
//   digit      out  4  last decoded digit, 4'hF for an invalid pattern
//   locked     out  1  monitor is tracking the sequence position
//   expected   out  3  table index (0-4) of the next expected digit
//   err        out  1  error flag
//   err_count  out  8  saturating error count
//
// All outputs are registered. They change only on an edge where sample=1
// (or reset=1) and hold otherwise.

module hex_seq_monitor #(
  parameter logic [3:0] D0 = 4'd3,
  parameter logic [3:0] D1 = 4'd1,
  parameter logic [3:0] D2 = 4'd4,
  parameter logic [3:0] D3 = 4'd5,
  parameter logic [3:0] D4 = 4'd9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] hex,
  input  logic       dir,
  input  logic       sample,
  input  logic       dut_rst,
  output logic [3:0] digit,
  output logic       locked,
  output logic [2:0] expected,
  output logic       err,
  output logic [7:0] err_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [3:0] digit_d;
  logic [2:0] expected_d;
  logic       err_d;
  logic [7:0] err_count_d;

  logic [3:0] dec;
  logic       hit;
  logic [2:0] hit_idx;
  logic [2:0] target;
  logic       bad;

  // Active-low segment decode; any pattern outside 0-9 (blank included)
  // maps to DIGIT_INVALID.
  function automatic logic [3:0] decode_seg(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      7'b1000000: d = 4'd0;
      7'b1111001: d = 4'd1;
      7'b0100100: d = 4'd2;
      7'b0110000: d = 4'd3;
      7'b0011001: d = 4'd4;
      7'b0010010: d = 4'd5;
      7'b0000010: d = 4'd6;
      7'b1111000: d = 4'd7;
      7'b0000000: d = 4'd8;
      7'b0010000: d = 4'd9;
      default:    d = DIGIT_INVALID;
    endcase
    return d;
  endfunction

  function automatic logic [3:0] entry(input logic [2:0] idx);
    logic [3:0] e;
    case (idx)
      3'd0:    e = D0;
      3'd1:    e = D1;
      3'd2:    e = D2;
      3'd3:    e = D3;
      default: e = D4;
    endcase
    return e;
  endfunction

  function automatic logic [2:0] inc5(input logic [2:0] i);
    return (i >= 3'd4) ? 3'd0 : i + 3'd1;
  endfunction

  function automatic logic [2:0] dec5(input logic [2:0] i);
    return (i == 3'd0) ? 3'd4 : i - 3'd1;
  endfunction

  function automatic logic [2:0] step5(input logic [2:0] i, input logic d);
    return d ? dec5(i) : inc5(i);
  endfunction

  // Table lookup of the decoded digit. The table entries are distinct, so
  // at most one index can hit.
  always_comb begin
    hit     = 1'b0;
    hit_idx = 3'd0;
    dec     = decode_seg(hex);
    for (int i = 0; i < 5; i++) begin
      if (!hit && (dec == entry(i[2:0]))) begin
        hit     = 1'b1;
        hit_idx = i[2:0];
      end
    end
  end

  // The next position is derived from the last digit actually seen, using
  // the direction presented with this sample. A direction change therefore
  // takes effect immediately rather than one step late through the
  // registered 'expected' value.
  assign target = step5(last_q, dir);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    digit_d     = digit;
    expected_d  = expected;
    err_d       = err;
    err_count_d = err_count;
    bad         = 1'b0;

    if (sample) begin
      digit_d = dec;

      if (dut_rst) begin
        // The display restarted at D0, whatever we thought it was doing.
        state_d    = TRACK;
        last_d     = 3'd0;
        expected_d = dir ? 3'd4 : 3'd1;
        bad        = (dec != D0);
      end else begin
        case (state_q)
          TRACK: begin
            if (dec == entry(target)) begin
              last_d     = target;
              expected_d = step5(target, dir);
            end else begin
              state_d = FAULT;
              bad     = 1'b1;
            end
          end
          default: begin
            // IDLE and FAULT re-lock on any digit that is in the table.
            if (hit) begin
              state_d    = TRACK;
              last_d     = hit_idx;
              expected_d = step5(hit_idx, dir);
            end else begin
              bad = 1'b1;
            end
          end
        endcase
      end

`ifdef HEX_SEQ_MONITOR_STICKY_ERR_EN
      err_d = err | bad;
`else
      err_d = bad;
`endif

      if (bad && (err_count != 8'hFF)) begin
        err_count_d = err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 3'd0;
      digit     <= DIGIT_INVALID;
      locked    <= 1'b0;
      expected  <= 3'd0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      digit     <= digit_d;
      locked    <= (state_d == TRACK);
      expected  <= expected_d;
      err       <= err_d;
      err_count <= err_count_d;
    end
  end

endmodule

// File: tb/tb_hex_seq_monitor.sv
// tb/tb_hex_seq_monitor.sv - directed self-checking bench for hex_seq_monitor

module tb_hex_seq_monitor;

`ifdef HEX_SEQ_MONITOR_STICKY_ERR_EN
  localparam logic STICKY = 1'b1;
`else
  localparam logic STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] hex = 7'h7F;
  logic       dir = 1'b0;
  logic       sample = 1'b0;
  logic       dut_rst = 1'b0;
  logic [3:0] digit;
  logic       locked;
  logic [2:0] expected;
  logic       err;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  hex_seq_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .hex       (hex),
    .dir       (dir),
    .sample    (sample),
    .dut_rst   (dut_rst),
    .digit     (digit),
    .locked    (locked),
    .expected  (expected),
    .err       (err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg(input int d);
    case (d)
      0:       return 7'b1000000;
      1:       return 7'b1111001;
      2:       return 7'b0100100;
      3:       return 7'b0110000;
      4:       return 7'b0011001;
      5:       return 7'b0010010;
      6:       return 7'b0000010;
      7:       return 7'b1111000;
      8:       return 7'b0000000;
      9:       return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_digit, input logic e_locked,
                         input logic [2:0] e_exp, input logic e_err, input logic [7:0] e_cnt);
    chk({tag, ".digit"}, {4'd0, digit}, {4'd0, e_digit});
    chk({tag, ".locked"}, {7'd0, locked}, {7'd0, e_locked});
    chk({tag, ".expected"}, {5'd0, expected}, {5'd0, e_exp});
    chk({tag, ".err"}, {7'd0, err}, {7'd0, e_err});
    chk({tag, ".err_count"}, err_count, e_cnt);
  endtask

  // One sampled display step; outputs are observed 1 time unit after the edge.
  task automatic step(input int d, input logic dr, input logic rs);
    hex     = seg(d);
    dir     = dr;
    dut_rst = rs;
    sample  = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset, with sample high to show reset wins.
    hex = seg(3); sample = 1'b1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'hF, 1'b0, 3'd0, 1'b0, 8'd0);
    reset = 1'b0;

    // Forward sequence 3,1,4,5,9,3.
    step(3, 0, 0); chk_all("fwd3", 4'd3, 1'b1, 3'd1, 1'b0, 8'd0);
    step(1, 0, 0); chk_all("fwd1", 4'd1, 1'b1, 3'd2, 1'b0, 8'd0);
    step(4, 0, 0); chk_all("fwd4", 4'd4, 1'b1, 3'd3, 1'b0, 8'd0);
    step(5, 0, 0); chk_all("fwd5", 4'd5, 1'b1, 3'd4, 1'b0, 8'd0);
    step(9, 0, 0); chk_all("fwd9", 4'd9, 1'b1, 3'd0, 1'b0, 8'd0);
    step(3, 0, 0); chk_all("fwdwrap", 4'd3, 1'b1, 3'd1, 1'b0, 8'd0);

    // Forward to 4, then reverse: 1,3,9.
    step(1, 0, 0); chk_all("pre1", 4'd1, 1'b1, 3'd2, 1'b0, 8'd0);
    step(4, 0, 0); chk_all("pre4", 4'd4, 1'b1, 3'd3, 1'b0, 8'd0);
    step(1, 1, 0); chk_all("bwd1", 4'd1, 1'b1, 3'd0, 1'b0, 8'd0);
    step(3, 1, 0); chk_all("bwd3", 4'd3, 1'b1, 3'd4, 1'b0, 8'd0);
    step(9, 1, 0); chk_all("bwd9", 4'd9, 1'b1, 3'd3, 1'b0, 8'd0);

    // Back to forward from 9: 3 then 1, reaching expected=2.
    step(3, 0, 0); chk_all("refwd3", 4'd3, 1'b1, 3'd1, 1'b0, 8'd0);
    step(1, 0, 0); chk_all("refwd1", 4'd1, 1'b1, 3'd2, 1'b0, 8'd0);

    // Wrong digit 8 while expecting entry 2, then re-lock on 5.
    step(8, 0, 0); chk_all("bad8", 4'd8, 1'b0, 3'd2, 1'b1, 8'd1);
    step(5, 0, 0); chk_all("relock5", 4'd5, 1'b1, 3'd4, STICKY, 8'd1);

    // Advance to expected=3, then display reset showing D0.
    step(9, 0, 0); chk_all("adv9", 4'd9, 1'b1, 3'd0, STICKY, 8'd1);
    step(3, 0, 0); chk_all("adv3", 4'd3, 1'b1, 3'd1, STICKY, 8'd1);
    step(1, 0, 0); chk_all("adv1", 4'd1, 1'b1, 3'd2, STICKY, 8'd1);
    step(4, 0, 0); chk_all("adv4", 4'd4, 1'b1, 3'd3, STICKY, 8'd1);
    step(3, 0, 1); chk_all("drst_ok", 4'd3, 1'b1, 3'd1, STICKY, 8'd1);

    // Same, but the display shows 1 on its reset step.
    step(1, 0, 0); chk_all("adv1b", 4'd1, 1'b1, 3'd2, STICKY, 8'd1);
    step(4, 0, 0); chk_all("adv4b", 4'd4, 1'b1, 3'd3, STICKY, 8'd1);
    step(1, 0, 1); chk_all("drst_bad", 4'd1, 1'b1, 3'd1, 1'b1, 8'd2);

    // sample=0: outputs hold despite hostile inputs.
    hex = seg(15); dir = 1'b1; dut_rst = 1'b1; sample = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all("hold", 4'd1, 1'b1, 3'd1, 1'b1, 8'd2);

    // One-cycle reset mid-sequence.
    hex = seg(4); dir = 1'b0; dut_rst = 1'b0; sample = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_all("midreset", 4'hF, 1'b0, 3'd0, 1'b0, 8'd0);

    // Blank in IDLE, then backward re-lock on 1, then a display reset backward.
    step(15, 0, 0); chk_all("blank", 4'hF, 1'b0, 3'd0, 1'b1, 8'd1);
    step(1, 1, 0); chk_all("idle_bwd1", 4'd1, 1'b1, 3'd0, STICKY, 8'd1);
    step(3, 1, 1); chk_all("drst_bwd", 4'd3, 1'b1, 3'd4, STICKY, 8'd1);

    // Saturation: 256 consecutive blank samples after reset.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 254; i++) step(15, 0, 0);
    chk("sat254", err_count, 8'hFE);
    step(15, 0, 0);
    chk("sat255", err_count, 8'hFF);
    step(15, 0, 0);
    chk_all("sat256", 4'hF, 1'b0, 3'd0, 1'b1, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
